// File: rtl/cntd_reload.sv
// Loadable, enabled down-counter with a one-cycle terminal-count strobe,
// a done level for one-shot use, and optional auto-reload from the last
// loaded value.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing loaded (or zero loaded); count holds, cnten ignored
// RUN   | counting down on each cnten; busy=1
// DONE  | one-shot exhausted; count=0, done=1 until load or reset
module cntd_reload #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  input  logic             cnten,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] rld;

  // State, count, reload register and tc strobe; load beats cnten.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      rld   <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count <= ldata;
        rld   <= ldata;
        state <= (ldata != '0) ? RUN : IDLE;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          RUN: begin
            if (cnten) begin
              if (count > ONE) begin
                count <= count - ONE;
              end else if (count == ONE) begin
                // Final enabled cycle: strobe tc alongside count reaching 0.
                count <= '0;
                tc    <= 1'b1;
                state <= reload_en ? RUN : DONE;
              end else begin
                // count==0 in RUN only follows an auto-reload tc.
                count <= rld;
              end
            end
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Status decoded directly from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_cntd_reload.sv
// Directed bench for cntd_reload (WIDTH=3): a cycle-level reference model
// tracks remaining count and mode; a negedge process compares every cycle,
// and literal expectations pin the model at key points.
module tb_cntd_reload;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [2:0] ldata = '0;
  logic       cnten = 1'b0;
  logic       reload_en = 1'b0;
  logic [2:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // reference model: mode 0=idle, 1=running, 2=finished
  int m_cnt = 0;
  int m_rld = 0;
  int m_tc  = 0;
  int m_mode = 0;

  cntd_reload #(.WIDTH(3)) dut (
    .clk(clk), .reset(reset), .load(load), .ldata(ldata), .cnten(cnten),
    .reload_en(reload_en), .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; model advances with the same inputs.
  task automatic step(input logic r, input logic ld, input logic [2:0] d,
                      input logic en, input logic re);
    reset = r; load = ld; ldata = d; cnten = en; reload_en = re;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_rld = 0; m_tc = 0; m_mode = 0;
    end else begin
      m_tc = 0;
      if (ld) begin
        m_cnt = d; m_rld = d; m_mode = (d != 0) ? 1 : 0;
      end else if (m_mode == 1 && en) begin
        if (m_cnt == 0) m_cnt = m_rld;
        else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_tc = 1;
            m_mode = re ? 1 : 2;
          end
        end
      end
    end
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("count", {29'd0, count}, m_cnt);
      check("tc",    {31'd0, tc},    m_tc);
      check("busy",  {31'd0, busy},  (m_mode == 1) ? 1 : 0);
      check("done",  {31'd0, done},  (m_mode == 2) ? 1 : 0);
    end
  end

  initial begin
    int tc_seen;
    int n;

    // reset wins over load
    step(1, 1, 3'd5, 1, 0);
    step(1, 1, 3'd5, 1, 0);
    chk_on = 1'b1;
    check("rst_count", {29'd0, count}, 0);
    check("rst_busy",  {31'd0, busy},  0);
    check("rst_done",  {31'd0, done},  0);
    check("rst_tc",    {31'd0, tc},    0);

    // one-shot from 3
    step(0, 1, 3'd3, 0, 0);
    check("os_load", {29'd0, count}, 3);
    step(0, 0, 3'd0, 1, 0);
    step(0, 0, 3'd0, 1, 0);
    check("os_cnt1", {29'd0, count}, 1);
    check("os_tc_early", {31'd0, tc}, 0);
    step(0, 0, 3'd0, 1, 0);
    check("os_zero", {29'd0, count}, 0);
    check("os_tc", {31'd0, tc}, 1);
    check("os_done", {31'd0, done}, 1);
    step(0, 0, 3'd0, 1, 0);
    step(0, 0, 3'd0, 1, 0);
    check("os_tc_after", {31'd0, tc}, 0);
    check("os_hold", {29'd0, count}, 0);
    check("os_done_hold", {31'd0, done}, 1);

    // auto-reload from 2: 1,0,2,1,0,2
    step(0, 1, 3'd2, 0, 1);
    tc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 3'd0, 1, 1);
      tc_seen += int'(tc);
      check("ar_busy", {31'd0, busy}, 1);
    end
    check("ar_tc_count", tc_seen, 2);
    check("ar_end", {29'd0, count}, 2);

    // gapped enable 1,0,1,1 from 4 -> 3,3,2,1
    step(0, 1, 3'd4, 0, 0);
    step(0, 0, 3'd0, 1, 0);
    step(0, 0, 3'd0, 0, 0);
    check("gap_hold", {29'd0, count}, 3);
    step(0, 0, 3'd0, 1, 0);
    step(0, 0, 3'd0, 1, 0);
    check("gap_cnt", {29'd0, count}, 1);
    // load collides with cnten: load wins
    step(0, 1, 3'd6, 1, 0);
    check("coll_count", {29'd0, count}, 6);
    check("coll_tc", {31'd0, tc}, 0);

    // load 0 -> idle, cnten ignored
    step(0, 1, 3'd0, 1, 0);
    step(0, 0, 3'd0, 1, 0);
    check("z_count", {29'd0, count}, 0);
    check("z_busy", {31'd0, busy}, 0);
    check("z_tc", {31'd0, tc}, 0);

    // full scale 7: tc on the 7th decrement (8 cycles counting the load)
    step(0, 1, 3'd7, 0, 0);
    n = 0;
    while (tc !== 1'b1 && n < 20) begin
      step(0, 0, 3'd0, 1, 0);
      n++;
    end
    check("fs_decrements", n, 7);

    // reset mid-run at count 3
    step(0, 1, 3'd5, 0, 0);
    step(0, 0, 3'd0, 1, 0);
    step(0, 0, 3'd0, 1, 0);
    check("mr_pre", {29'd0, count}, 3);
    step(1, 0, 3'd0, 1, 0);
    check("mr_count", {29'd0, count}, 0);
    check("mr_busy", {31'd0, busy}, 0);
    step(0, 0, 3'd0, 1, 0);
    check("mr_idle", {29'd0, count}, 0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
